// File: rtl/rv32im_csr_mregs.sv
// rv32im machine-mode CSR file: M-mode registers, trap/mret state, counters.
// Optional mcountinhibit at 0x320 when CSR_COUNTER_INHIBIT_EN is defined.
module rv32im_csr_mregs #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] val_csr_i,
  input  logic        csr_write_en_i,
  input  logic        csr_read_en_i,
  output logic [31:0] val_csr_o,
  output logic [31:0] csr_status_o,
  output logic [1:0]  priviledge_mode_o,
  output logic        illegal_csr_o,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        instret_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o
);

  logic        mie_b;
  logic        mpie_b;
  logic [31:0] mie_q;
  logic [29:0] mtvec_base;
  logic [1:0]  mtvec_mode;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
  logic        cy_inh;
  logic        ir_inh;
  logic        impl;
  logic        ro;
  logic        wr_ok;
  logic [31:0] rdata;

  assign priviledge_mode_o = 2'b11;
  assign csr_status_o = {19'b0, 2'b11, 3'b0, mpie_b,
                         3'b0, mie_b, 3'b0};
  assign mepc_o = mepc_q;

  always_comb begin
    impl = 1'b0;
    ro   = 1'b0;
    case (csr_addr_i)
      12'h300, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB80, 12'hB02, 12'hB82:
        impl = 1'b1;
      12'h301, 12'h344, 12'hF14,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: begin
        impl = 1'b1;
        ro   = 1'b1;
      end
`ifdef CSR_COUNTER_INHIBIT_EN
      12'h320:
        impl = 1'b1;
`endif
      default: ;
    endcase
  end

  assign illegal_csr_o =
    ((csr_read_en_i | csr_write_en_i) & ~impl) |
    (csr_write_en_i & ro);

  // trap and mret both outrank a CSR write on the same edge
  assign wr_ok = csr_write_en_i & ~illegal_csr_o
               & ~trap_i & ~mret_i;

`ifdef CSR_COUNTER_INHIBIT_EN
  logic cy_inh_q;
  logic ir_inh_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cy_inh_q <= 1'b0;
      ir_inh_q <= 1'b0;
    end else if (wr_ok && csr_addr_i == 12'h320) begin
      cy_inh_q <= val_csr_i[0];
      ir_inh_q <= val_csr_i[2];
    end
  end

  assign cy_inh = cy_inh_q;
  assign ir_inh = ir_inh_q;
`else
  assign cy_inh = 1'b0;
  assign ir_inh = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0;
    case (csr_addr_i)
      12'h300: rdata = csr_status_o;
      12'h301: rdata = MISA_VALUE;
      12'h304: rdata = mie_q;
      12'h305: rdata = {mtvec_base, mtvec_mode};
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'hB00, 12'hC00: rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata = minstret_q[31:0];
      12'hB82, 12'hC82: rdata = minstret_q[63:32];
      12'hF14: rdata = HART_ID;
`ifdef CSR_COUNTER_INHIBIT_EN
      12'h320: rdata = {29'b0, ir_inh, 1'b0, cy_inh};
`endif
      default: rdata = 32'h0;
    endcase
  end

  assign val_csr_o = csr_read_en_i ? rdata : 32'h0;

  always_comb begin
    trap_vector_o = {mtvec_base, 2'b00};
    if (mtvec_mode == 2'b01 && trap_cause_i[31])
      trap_vector_o = {mtvec_base, 2'b00}
                    + {25'b0, trap_cause_i[4:0], 2'b00};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mie_b      <= 1'b0;
      mpie_b     <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_base <= MTVEC_RESET[31:2];
      mtvec_mode <= MTVEC_RESET[1:0];
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
    end else if (trap_i) begin
      mepc_q   <= {trap_pc_i[31:2], 2'b00};
      mcause_q <= trap_cause_i;
      mtval_q  <= trap_tval_i;
      mpie_b   <= mie_b;
      mie_b    <= 1'b0;
    end else if (mret_i) begin
      mie_b  <= mpie_b;
      mpie_b <= 1'b1;
    end else if (wr_ok) begin
      case (csr_addr_i)
        12'h300: begin
          mie_b  <= val_csr_i[3];
          mpie_b <= val_csr_i[7];
        end
        12'h304: mie_q <= val_csr_i & 32'h0000_0888;
        12'h305: begin
          mtvec_base <= val_csr_i[31:2];
          // reserved MODE encodings keep the current mode
          if (!val_csr_i[1])
            mtvec_mode <= val_csr_i[1:0];
        end
        12'h340: mscratch_q <= val_csr_i;
        12'h341: mepc_q <= {val_csr_i[31:2], 2'b00};
        12'h342: mcause_q <= val_csr_i;
        12'h343: mtval_q <= val_csr_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      mcycle_q <= 64'h0;
    else if (wr_ok && csr_addr_i == 12'hB00)
      mcycle_q[31:0] <= val_csr_i;
    else if (wr_ok && csr_addr_i == 12'hB80)
      mcycle_q[63:32] <= val_csr_i;
    else if (!cy_inh)
      mcycle_q <= mcycle_q + 64'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      minstret_q <= 64'h0;
    else if (wr_ok && csr_addr_i == 12'hB02)
      minstret_q[31:0] <= val_csr_i;
    else if (wr_ok && csr_addr_i == 12'hB82)
      minstret_q[63:32] <= val_csr_i;
    else if (instret_i && !ir_inh)
      minstret_q <= minstret_q + 64'd1;
  end

  logic unused_ok;
  assign unused_ok = ^trap_pc_i[1:0];

endmodule

// File: tb/tb_rv32im_csr_mregs.sv
// Directed self-checking bench for rv32im_csr_mregs.
// Inputs change and outputs are sampled on the falling edge.
module tb_rv32im_csr_mregs;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [11:0] csr_addr_i;
  logic [31:0] val_csr_i;
  logic        csr_write_en_i;
  logic        csr_read_en_i;
  logic [31:0] val_csr_o;
  logic [31:0] csr_status_o;
  logic [1:0]  priviledge_mode_o;
  logic        illegal_csr_o;
  logic        trap_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_tval_i;
  logic        mret_i;
  logic        instret_i;
  logic [31:0] trap_vector_o;
  logic [31:0] mepc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  rv32im_csr_mregs dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .csr_addr_i        (csr_addr_i),
    .val_csr_i         (val_csr_i),
    .csr_write_en_i    (csr_write_en_i),
    .csr_read_en_i     (csr_read_en_i),
    .val_csr_o         (val_csr_o),
    .csr_status_o      (csr_status_o),
    .priviledge_mode_o (priviledge_mode_o),
    .illegal_csr_o     (illegal_csr_o),
    .trap_i            (trap_i),
    .trap_cause_i      (trap_cause_i),
    .trap_pc_i         (trap_pc_i),
    .trap_tval_i       (trap_tval_i),
    .mret_i            (mret_i),
    .instret_i         (instret_i),
    .trap_vector_o     (trap_vector_o),
    .mepc_o            (mepc_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag,
                        input logic [11:0] a,
                        input logic [31:0] exp);
    csr_addr_i    = a;
    csr_read_en_i = 1'b1;
    #1;
    chk(tag, val_csr_o, exp);
    csr_read_en_i = 1'b0;
  endtask

  // called on a falling edge; returns on the next one
  task automatic wr(input logic [11:0] a,
                    input logic [31:0] v);
    csr_addr_i     = a;
    val_csr_i      = v;
    csr_write_en_i = 1'b1;
    @(negedge clk_i);
    csr_write_en_i = 1'b0;
  endtask

  initial begin
    rst_n_i        = 1'b0;
    csr_addr_i     = 12'h0;
    val_csr_i      = 32'h0;
    csr_write_en_i = 1'b0;
    csr_read_en_i  = 1'b0;
    trap_i         = 1'b0;
    trap_cause_i   = 32'h0;
    trap_pc_i      = 32'h0;
    trap_tval_i    = 32'h0;
    mret_i         = 1'b0;
    instret_i      = 1'b0;
    repeat (2) @(negedge clk_i);
    rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    rd_chk("mstatus", 12'h300, 32'h0000_1800);
    chk("mstatus_ill", {31'b0, illegal_csr_o}, 32'h0);
    rd_chk("misa", 12'h301, 32'h4000_1100);
    rd_chk("mhartid", 12'hF14, 32'h0);
    chk("priv", {30'b0, priviledge_mode_o}, 32'h3);
    rd_chk("no_read_en", 12'h300, 32'h0000_1800);
    #1;
    chk("idle_out", val_csr_o, 32'h0);
    rd_chk("unimpl_rd", 12'h7C0, 32'h0);
    csr_read_en_i = 1'b1;
    #1;
    chk("unimpl_ill", {31'b0, illegal_csr_o}, 32'h1);
    csr_read_en_i = 1'b0;
    @(negedge clk_i);

    wr(12'h305, 32'h8000_0003);
    rd_chk("mtvec_mode3", 12'h305, 32'h8000_0000);
    trap_cause_i = 32'h8000_0007;
    #1;
    chk("vec_direct", trap_vector_o, 32'h8000_0000);
    @(negedge clk_i);
    wr(12'h305, 32'h8000_0101);
    rd_chk("mtvec_vec", 12'h305, 32'h8000_0101);
    chk("vec_irq", trap_vector_o, 32'h8000_011C);
    trap_cause_i = 32'h0000_0007;
    #1;
    chk("vec_exc", trap_vector_o, 32'h8000_0100);
    @(negedge clk_i);

    wr(12'h304, 32'hFFFF_FFFF);
    rd_chk("mie_mask", 12'h304, 32'h0000_0888);
    @(negedge clk_i);
    wr(12'h341, 32'h0000_1237);
    rd_chk("mepc_align", 12'h341, 32'h0000_1234);
    @(negedge clk_i);
    wr(12'h301, 32'h0);
    rd_chk("misa_ro", 12'h301, 32'h4000_1100);

    csr_addr_i     = 12'h344;
    csr_write_en_i = 1'b1;
    #1;
    chk("mip_wr_ill", {31'b0, illegal_csr_o}, 32'h1);
    csr_write_en_i = 1'b0;
    rd_chk("mip", 12'h344, 32'h0);
    @(negedge clk_i);

    wr(12'h300, 32'h0000_0008);
    rd_chk("mstatus_mie", 12'h300, 32'h0000_1808);
    @(negedge clk_i);
    trap_i       = 1'b1;
    trap_pc_i    = 32'h0000_1236;
    trap_cause_i = 32'h2;
    trap_tval_i  = 32'h0000_DEAD;
    @(negedge clk_i);
    trap_i = 1'b0;
    chk("trap_mepc_o", mepc_o, 32'h0000_1234);
    rd_chk("trap_mepc", 12'h341, 32'h0000_1234);
    rd_chk("trap_mcause", 12'h342, 32'h2);
    rd_chk("trap_mtval", 12'h343, 32'h0000_DEAD);
    chk("trap_status", csr_status_o, 32'h0000_1880);
    @(negedge clk_i);
    mret_i = 1'b1;
    @(negedge clk_i);
    mret_i = 1'b0;
    rd_chk("mret_status", 12'h300, 32'h0000_1888);
    @(negedge clk_i);

    wr(12'h340, 32'h0000_0055);
    rd_chk("mscratch", 12'h340, 32'h0000_0055);
    @(negedge clk_i);
    trap_i         = 1'b1;
    mret_i         = 1'b1;
    trap_pc_i      = 32'h0000_0100;
    trap_cause_i   = 32'h5;
    trap_tval_i    = 32'h7;
    csr_addr_i     = 12'h340;
    val_csr_i      = 32'h0000_00AA;
    csr_write_en_i = 1'b1;
    @(negedge clk_i);
    trap_i         = 1'b0;
    mret_i         = 1'b0;
    csr_write_en_i = 1'b0;
    rd_chk("col_mscratch", 12'h340, 32'h0000_0055);
    rd_chk("col_mepc", 12'h341, 32'h0000_0100);
    rd_chk("col_mcause", 12'h342, 32'h5);
    rd_chk("col_status", 12'h300, 32'h0000_1880);
    @(negedge clk_i);

    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    repeat (2) @(negedge clk_i);
    rd_chk("mcycleh_carry", 12'hB80, 32'h1);
    rd_chk("mcycle_wrap", 12'hB00, 32'h1);
    csr_addr_i     = 12'hC00;
    val_csr_i      = 32'h0000_1234;
    csr_write_en_i = 1'b1;
    #1;
    chk("cycle_ro_ill", {31'b0, illegal_csr_o}, 32'h1);
    @(negedge clk_i);
    csr_write_en_i = 1'b0;
    rd_chk("mcycle_keep", 12'hB00, 32'h2);
    rd_chk("cycle_shadow", 12'hC80, 32'h1);
    @(negedge clk_i);

    wr(12'hB02, 32'd10);
    instret_i = 1'b1;
    repeat (3) @(negedge clk_i);
    instret_i = 1'b0;
    rd_chk("minstret", 12'hB02, 32'd13);
    rd_chk("instret_shadow", 12'hC02, 32'd13);
    rd_chk("minstreth", 12'hB82, 32'h0);
    @(negedge clk_i);

`ifdef CSR_COUNTER_INHIBIT_EN
    wr(12'h320, 32'hFFFF_FFFF);
    rd_chk("mcinh_mask", 12'h320, 32'h5);
    @(negedge clk_i);
    wr(12'hB00, 32'h0000_0100);
    instret_i = 1'b1;
    repeat (10) @(negedge clk_i);
    instret_i = 1'b0;
    rd_chk("cy_frozen", 12'hB00, 32'h0000_0100);
    rd_chk("ir_frozen", 12'hB02, 32'd13);
`else
    wr(12'h320, 32'h5);
    csr_addr_i    = 12'h320;
    csr_read_en_i = 1'b1;
    #1;
    chk("mcinh_ill", {31'b0, illegal_csr_o}, 32'h1);
    chk("mcinh_rd0", val_csr_o, 32'h0);
    csr_read_en_i = 1'b0;
    @(negedge clk_i);
    wr(12'hB00, 32'h0000_0100);
    repeat (3) @(negedge clk_i);
    rd_chk("cy_running", 12'hB00, 32'h0000_0103);
`endif

    wr(12'h340, 32'h0000_0077);
    #2;
    rst_n_i = 1'b0;
    #1;
    rd_chk("arst_mscratch", 12'h340, 32'h0);
    rd_chk("arst_mcycle", 12'hB00, 32'h0);
    rd_chk("arst_mtvec", 12'h305, 32'h0);
    rd_chk("arst_status", 12'h300, 32'h0000_1800);
    rst_n_i = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
